// File: rtl/pred_validator.sv
// Prediction validator: keeps in-flight value predictions in a circular FIFO,
// pairs them in order with retiring commit results, and returns registered
// per-prediction feedback (pc, actual, confidence, mispredict) to the predictor.
//
// Interface semantics: every input lane is valid-only. A lane is sampled on the
// rising edge when its valid bit is high; there is no ready. A push that finds
// no room is dropped and flags overflow_o. A commit with no stored entry is
// dropped and flags underflow_o. Feedback appears exactly one cycle after the
// commit and is qualified by fb_valid_o.
module pred_validator #(
    parameter int P_NUM_PRED   = 2,
    parameter int P_FIFO_DEPTH = 16
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [P_NUM_PRED-1:0][31:0]         pred_pc_i,
    input  logic [P_NUM_PRED-1:0][31:0]         pred_result_i,
    input  logic [P_NUM_PRED-1:0]               pred_conf_i,
    input  logic [P_NUM_PRED-1:0]               pred_valid_i,
    input  logic [P_NUM_PRED-1:0][31:0]         commit_actual_i,
    input  logic [P_NUM_PRED-1:0]               commit_valid_i,
    input  logic                                flush_i,
    output logic [P_NUM_PRED-1:0][31:0]         fb_pc_o,
    output logic [P_NUM_PRED-1:0][31:0]         fb_actual_o,
    output logic [P_NUM_PRED-1:0]               fb_mispredict_o,
    output logic [P_NUM_PRED-1:0]               fb_conf_o,
    output logic [P_NUM_PRED-1:0]               fb_valid_o,
    output logic [$clog2(P_FIFO_DEPTH):0]       occupancy_o,
    output logic                                overflow_o,
    output logic                                underflow_o
);

    localparam int PW = $clog2(P_FIFO_DEPTH);
    localparam int CW = PW + 1;

    // Payload storage; deliberately not reset.
    logic [31:0] mem_pc   [P_FIFO_DEPTH];
    logic [31:0] mem_res  [P_FIFO_DEPTH];
    logic        mem_conf [P_FIFO_DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;

    // Next-state signals produced by the pairing/allocation logic.
    int                               pop_n;
    int                               push_n;
    logic                             blocked;
    logic                             udf_set;
    logic                             ovf_set;
    logic [PW-1:0]                    raddr;
    logic [P_NUM_PRED-1:0]            we;
    logic [P_NUM_PRED-1:0][PW-1:0]    waddr;
    logic [P_NUM_PRED-1:0][31:0]      fb_pc_n;
    logic [P_NUM_PRED-1:0][31:0]      fb_act_n;
    logic [P_NUM_PRED-1:0]            fb_mis_n;
    logic [P_NUM_PRED-1:0]            fb_conf_n;
    logic [P_NUM_PRED-1:0]            fb_val_n;
    logic [CW-1:0]                    occ_n;

    // Pair valid commits with the oldest entries (pops first), then allocate
    // tail slots to valid predictions while room remains after those pops.
    always_comb begin
        pop_n     = 0;
        push_n    = 0;
        blocked   = 1'b0;
        udf_set   = 1'b0;
        ovf_set   = 1'b0;
        raddr     = '0;
        we        = '0;
        waddr     = '0;
        fb_pc_n   = '0;
        fb_act_n  = '0;
        fb_mis_n  = '0;
        fb_conf_n = '0;
        fb_val_n  = '0;
        for (int j = 0; j < P_NUM_PRED; j++) begin
            if (commit_valid_i[j]) begin
                if (pop_n < int'(occupancy_o)) begin
                    raddr = head + pop_n[PW-1:0];
                    for (int k = 0; k < P_NUM_PRED; k++) begin
                        if (k == pop_n) begin
                            fb_val_n[k]  = 1'b1;
                            fb_pc_n[k]   = mem_pc[raddr];
                            fb_act_n[k]  = commit_actual_i[j];
                            fb_conf_n[k] = mem_conf[raddr];
                            fb_mis_n[k]  = (mem_res[raddr] != commit_actual_i[j]);
                        end
                    end
                    pop_n = pop_n + 1;
                end else begin
                    udf_set = 1'b1;
                end
            end
        end
        for (int j = 0; j < P_NUM_PRED; j++) begin
            if (pred_valid_i[j]) begin
                // Once a lower lane is refused, higher lanes are refused too.
                if (!blocked && (int'(occupancy_o) - pop_n + push_n < P_FIFO_DEPTH)) begin
                    we[j]    = 1'b1;
                    waddr[j] = tail + push_n[PW-1:0];
                    push_n   = push_n + 1;
                end else begin
                    blocked = 1'b1;
                    ovf_set = 1'b1;
                end
            end
        end
        occ_n = occupancy_o - pop_n[CW-1:0] + push_n[CW-1:0];
    end

    // Payload write for accepted pushes; flush and reset discard them.
    always_ff @(posedge clk_i) begin
        for (int j = 0; j < P_NUM_PRED; j++) begin
            if (rst_ni && !flush_i && we[j]) begin
                mem_pc[waddr[j]]   <= pred_pc_i[j];
                mem_res[waddr[j]]  <= pred_result_i[j];
                mem_conf[waddr[j]] <= pred_conf_i[j];
            end
        end
    end

    // Pointers, occupancy, registered feedback and sticky error flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head            <= '0;
            tail            <= '0;
            occupancy_o     <= '0;
            fb_pc_o         <= '0;
            fb_actual_o     <= '0;
            fb_mispredict_o <= '0;
            fb_conf_o       <= '0;
            fb_valid_o      <= '0;
            overflow_o      <= 1'b0;
            underflow_o     <= 1'b0;
        end else if (flush_i) begin
            // Same-cycle pushes/commits vanish; flags are left as they are.
            head            <= tail;
            occupancy_o     <= '0;
            fb_pc_o         <= '0;
            fb_actual_o     <= '0;
            fb_mispredict_o <= '0;
            fb_conf_o       <= '0;
            fb_valid_o      <= '0;
        end else begin
            head            <= head + pop_n[PW-1:0];
            tail            <= tail + push_n[PW-1:0];
            occupancy_o     <= occ_n;
            fb_pc_o         <= fb_pc_n;
            fb_actual_o     <= fb_act_n;
            fb_mispredict_o <= fb_mis_n;
            fb_conf_o       <= fb_conf_n;
            fb_valid_o      <= fb_val_n;
            if (ovf_set) overflow_o  <= 1'b1;
            if (udf_set) underflow_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pred_validator.sv
// Bench for pred_validator (2 lanes, depth 16): queue-based reference model,
// a per-cycle compare process, and directed scenarios with literal checks.
module tb_pred_validator;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0][31:0] pred_pc;
    logic [1:0][31:0] pred_res;
    logic [1:0]       pred_conf;
    logic [1:0]       pred_valid;
    logic [1:0][31:0] commit_act;
    logic [1:0]       commit_valid;
    logic             flush;

    logic [1:0][31:0] fb_pc;
    logic [1:0][31:0] fb_act;
    logic [1:0]       fb_mis;
    logic [1:0]       fb_conf;
    logic [1:0]       fb_val;
    logic [4:0]       occ;
    logic             ovf;
    logic             udf;

    int n_checks = 0;
    int n_errors = 0;

    pred_validator #(.P_NUM_PRED(2), .P_FIFO_DEPTH(16)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .pred_pc_i       (pred_pc),
        .pred_result_i   (pred_res),
        .pred_conf_i     (pred_conf),
        .pred_valid_i    (pred_valid),
        .commit_actual_i (commit_act),
        .commit_valid_i  (commit_valid),
        .flush_i         (flush),
        .fb_pc_o         (fb_pc),
        .fb_actual_o     (fb_act),
        .fb_mispredict_o (fb_mis),
        .fb_conf_o       (fb_conf),
        .fb_valid_o      (fb_val),
        .occupancy_o     (occ),
        .overflow_o      (ovf),
        .underflow_o     (udf)
    );

    // Clock
    always #5 clk = ~clk;

    // Reference model: a plain queue of in-flight predictions.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] res;
        logic        conf;
    } ent_t;

    ent_t             q[$];
    logic [1:0][31:0] exp_pc   = '0;
    logic [1:0][31:0] exp_act  = '0;
    logic [1:0]       exp_mis  = '0;
    logic [1:0]       exp_conf = '0;
    logic [1:0]       exp_val  = '0;
    logic [4:0]       exp_occ  = '0;
    logic             exp_ovf  = 1'b0;
    logic             exp_udf  = 1'b0;

    initial begin
        int   n;
        ent_t e;
        forever begin
            @(posedge clk or negedge rst_n);
            exp_pc   = '0;
            exp_act  = '0;
            exp_mis  = '0;
            exp_conf = '0;
            exp_val  = '0;
            if (!rst_n) begin
                q.delete();
                exp_ovf = 1'b0;
                exp_udf = 1'b0;
            end else if (flush) begin
                q.delete();
            end else begin
                n = 0;
                for (int j = 0; j < 2; j++) begin
                    if (commit_valid[j]) begin
                        if (q.size() > 0) begin
                            e = q.pop_front();
                            exp_pc[n]   = e.pc;
                            exp_act[n]  = commit_act[j];
                            exp_mis[n]  = (e.res != commit_act[j]);
                            exp_conf[n] = e.conf;
                            exp_val[n]  = 1'b1;
                            n++;
                        end else begin
                            exp_udf = 1'b1;
                        end
                    end
                end
                for (int j = 0; j < 2; j++) begin
                    if (pred_valid[j]) begin
                        if (q.size() < 16) begin
                            e.pc   = pred_pc[j];
                            e.res  = pred_res[j];
                            e.conf = pred_conf[j];
                            q.push_back(e);
                        end else begin
                            exp_ovf = 1'b1;
                        end
                    end
                end
            end
            exp_occ = 5'(q.size());
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    // Compare process: every falling edge, DUT outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            check("fb_valid", 64'(fb_val), 64'(exp_val));
            check("fb_pc", 64'(fb_pc), 64'(exp_pc));
            check("fb_actual", 64'(fb_act), 64'(exp_act));
            check("fb_mispredict", 64'(fb_mis), 64'(exp_mis));
            check("fb_conf", 64'(fb_conf), 64'(exp_conf));
            check("occupancy", 64'(occ), 64'(exp_occ));
            check("overflow", 64'(ovf), 64'(exp_ovf));
            check("underflow", 64'(udf), 64'(exp_udf));
        end
    end

    // Driver tasks
    task automatic clr();
        pred_pc      = '0;
        pred_res     = '0;
        pred_conf    = '0;
        pred_valid   = '0;
        commit_act   = '0;
        commit_valid = '0;
        flush        = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int lane, input logic [31:0] pc, input logic [31:0] res, input logic conf);
        pred_valid[lane] = 1'b1;
        pred_pc[lane]    = pc;
        pred_res[lane]   = res;
        pred_conf[lane]  = conf;
    endtask

    task automatic commit(input int lane, input logic [31:0] act);
        commit_valid[lane] = 1'b1;
        commit_act[lane]   = act;
    endtask

    initial begin
        clr();
        repeat (3) tick();
        check("reset occupancy", 64'(occ), 64'd0);
        check("reset fb_valid", 64'(fb_val), 64'd0);
        rst_n = 1'b1;
        tick();

        // Single lane-0 prediction, committed correctly two cycles later.
        push(0, 32'h100, 32'd5, 1'b1);
        tick();
        clr();
        tick();
        commit(0, 32'd5);
        tick();
        clr();
        check("s1 fb_valid", 64'(fb_val), 64'b01);
        check("s1 fb_pc0", 64'(fb_pc[0]), 64'h100);
        check("s1 mispredict0", 64'(fb_mis[0]), 64'd0);
        check("s1 conf0", 64'(fb_conf[0]), 64'd1);
        check("s1 occupancy", 64'(occ), 64'd0);

        // Lane-1-only push and commit, mispredicted; compacted onto lane 0.
        push(1, 32'h200, 32'd7, 1'b0);
        tick();
        clr();
        commit(1, 32'd9);
        tick();
        clr();
        check("s2 fb_valid", 64'(fb_val), 64'b01);
        check("s2 fb_pc0", 64'(fb_pc[0]), 64'h200);
        check("s2 fb_actual0", 64'(fb_act[0]), 64'd9);
        check("s2 mispredict0", 64'(fb_mis[0]), 64'd1);

        // Five entries, then flush with pushes and a commit in the same cycle.
        push(0, 32'h400, 32'd1, 1'b0); push(1, 32'h404, 32'd2, 1'b1); tick(); clr();
        push(0, 32'h408, 32'd3, 1'b0); push(1, 32'h40c, 32'd4, 1'b1); tick(); clr();
        push(0, 32'h410, 32'd5, 1'b0); tick(); clr();
        check("s3 occupancy before flush", 64'(occ), 64'd5);
        flush = 1'b1;
        push(0, 32'h500, 32'd0, 1'b0); push(1, 32'h504, 32'd0, 1'b0);
        commit(0, 32'd1);
        tick();
        clr();
        check("s3 occupancy", 64'(occ), 64'd0);
        check("s3 fb_valid", 64'(fb_val), 64'd0);
        check("s3 flags", 64'({ovf, udf}), 64'd0);
        // Flush while empty with commits must not raise underflow.
        flush = 1'b1;
        commit(0, 32'd1); commit(1, 32'd2);
        tick();
        clr();
        check("s3 flush underflow", 64'(udf), 64'd0);

        // One entry, two commits: lane 0 served, second commit underflows.
        push(0, 32'h300, 32'd3, 1'b1);
        tick();
        clr();
        commit(0, 32'd3); commit(1, 32'd3);
        tick();
        clr();
        check("s4 fb_valid", 64'(fb_val), 64'b01);
        check("s4 fb_pc0", 64'(fb_pc[0]), 64'h300);
        check("s4 underflow", 64'(udf), 64'd1);
        check("s4 occupancy", 64'(occ), 64'd0);

        // Fill to 16 with two pushes per cycle, then overflow on the 9th cycle.
        for (int i = 0; i < 9; i++) begin
            push(0, 32'h1000 + 32'(i * 8), 32'(i), 1'b0);
            push(1, 32'h1004 + 32'(i * 8), 32'(i + 100), 1'b1);
            tick();
            clr();
            if (i == 7) begin
                check("s5 occupancy full", 64'(occ), 64'd16);
                check("s5 no overflow yet", 64'(ovf), 64'd0);
            end
        end
        check("s5 occupancy after drop", 64'(occ), 64'd16);
        check("s5 overflow", 64'(ovf), 64'd1);
        // Two commits free room for two same-cycle pushes.
        commit(0, 32'd0); commit(1, 32'd100);
        push(0, 32'h2000, 32'd50, 1'b1); push(1, 32'h2004, 32'd51, 1'b0);
        tick();
        clr();
        check("s5 occupancy stays", 64'(occ), 64'd16);
        check("s5 fb_valid", 64'(fb_val), 64'b11);
        check("s5 fb_pc1", 64'(fb_pc[1]), 64'h1004);
        for (int i = 0; i < 8; i++) begin
            commit(0, 32'd77); commit(1, 32'd51);
            tick();
            clr();
        end
        check("s5 drained", 64'(occ), 64'd0);
        check("s5 last pc1", 64'(fb_pc[1]), 64'h2004);
        check("s5 last mispredict", 64'(fb_mis), 64'b01);

        // 40 push/commit pairs with a lag of 3 through the wrapping FIFO.
        for (int i = 0; i < 43; i++) begin
            if (i < 40) push(int'($urandom_range(0, 1)), 32'h3000 + 32'(i * 4),
                             32'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            if (i >= 3) commit(int'($urandom_range(0, 1)), 32'($urandom_range(0, 3)));
            tick();
            clr();
        end
        check("s6 occupancy", 64'(occ), 64'd0);

        // Reset mid-stream: outputs clear immediately, same-edge inputs ignored.
        push(0, 32'h600, 32'd1, 1'b1); push(1, 32'h604, 32'd2, 1'b1);
        tick();
        push(0, 32'h608, 32'd3, 1'b1);
        commit(0, 32'd1);
        tick();
        check("s7 fb_valid before reset", 64'(fb_val), 64'b01);
        commit(0, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("s7 async fb_valid", 64'(fb_val), 64'd0);
        check("s7 async fb_pc", 64'(fb_pc), 64'd0);
        check("s7 async occupancy", 64'(occ), 64'd0);
        check("s7 async flags", 64'({ovf, udf}), 64'd0);
        tick();
        check("s7 held occupancy", 64'(occ), 64'd0);
        clr();
        rst_n = 1'b1;
        tick();
        push(0, 32'h700, 32'd8, 1'b0);
        tick();
        clr();
        check("s7 resume occupancy", 64'(occ), 64'd1);
        commit(0, 32'd8);
        tick();
        clr();
        check("s7 resume fb_pc0", 64'(fb_pc[0]), 64'h700);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pred_validator.md
PRED_VALIDATOR -- requirements
Module: pred_validator

Interface
REQ-001 SHALL have parameter P_NUM_PRED, default 2, lanes per cycle; legal values are 1 and 2.
REQ-002 SHALL have parameter P_FIFO_DEPTH, default 16, in-flight prediction entries; power of 2, at least 4.
REQ-003 SHALL have port clk_i, input, 1, sole clock, all state on rising edge.
REQ-004 SHALL have port rst_ni, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port pred_pc_i, input, P_NUM_PRED x 32, PC of each prediction from the predictor.
REQ-006 SHALL have port pred_result_i, input, P_NUM_PRED x 32, predicted value.
REQ-007 SHALL have port pred_conf_i, input, P_NUM_PRED, prediction confidence saturated.
REQ-008 SHALL have port pred_valid_i, input, P_NUM_PRED, qualifies each pred lane.
REQ-009 SHALL have port commit_actual_i, input, P_NUM_PRED x 32, true result of retiring instructions, in program order.
REQ-010 SHALL have port commit_valid_i, input, P_NUM_PRED, qualifies each commit lane.
REQ-011 SHALL have port flush_i, input, 1, pipeline flush that discards all in-flight entries.
REQ-012 SHALL have ports fb_pc_o, fb_actual_o (P_NUM_PRED x 32) and fb_mispredict_o, fb_conf_o, fb_valid_o (P_NUM_PRED), all outputs, forming the feedback to the predictor.
REQ-013 SHALL have port occupancy_o, output, $clog2(P_FIFO_DEPTH)+1, current entry count.
REQ-014 SHALL have ports overflow_o and underflow_o, outputs, 1 each, sticky error flags.

Function
REQ-015 SHALL store each accepted prediction {pc, result, conf} in a circular FIFO of P_FIFO_DEPTH entries.
REQ-016 SHALL compact pushes: valid pred lanes are written in ascending lane order to consecutive slots (pred_valid_i=2'b10 writes lane 1 into the tail slot).
REQ-017 SHALL compact pops: the k-th valid commit lane (ascending order) pairs with the k-th oldest entry.
REQ-018 SHALL, per pairing, register on the next edge: fb_pc_o=entry pc, fb_actual_o=commit value, fb_conf_o=entry conf, fb_mispredict_o=(entry result != commit value), fb_valid_o=1.
REQ-019 SHALL place feedback results compacted onto output lanes 0..n-1 and drive the remaining lanes with fb_valid_o=0; latency is exactly 1 cycle from commit to feedback.
REQ-020 SHALL drive fb_* data to 0 on lanes where fb_valid_o=0.
REQ-021 SHALL process pops before pushes in a cycle; a push is accepted only if (count - pops + accepted pushes so far) < P_FIFO_DEPTH.
REQ-022 SHALL drop each push rejected for lack of space and set overflow_o; a lane-0 rejection also rejects lane 1.
REQ-023 SHALL treat a commit with no matching entry (FIFO empty, or fewer entries than valid commits) as underflow: no feedback for that lane, underflow_o set.
REQ-024 SHALL, on flush_i=1, drive count to 0 and equalize head and tail on that edge, discarding same-cycle pushes and commits; the same-cycle commits produce no feedback and do not set underflow_o.
REQ-025 SHALL wrap head and tail pointers modulo P_FIFO_DEPTH without a bubble.
REQ-026 SHALL update occupancy_o as a registered count equal to the FIFO contents after each edge.
REQ-027 SHALL keep overflow_o and underflow_o high until reset once set; flush does not clear them.
REQ-028 SHALL, when P_NUM_PRED=1, implement the same behaviour with a single lane.

Reset
REQ-029 SHALL, on rst_ni=0 and asynchronously, clear head, tail, occupancy_o, fb_valid_o, all fb_* data, overflow_o and underflow_o to 0.
REQ-030 SHALL ignore all inputs while rst_ni=0 and leave FIFO payload storage unreset.
REQ-031 SHALL resume normal operation on the first rising edge after rst_ni deasserts; reset during a push or commit cycle discards that push or commit.

Verification
REQ-032 SHALL cover this scenario: push pc=0x100, result=5, conf=1 on lane 0; two cycles later commit 5 on lane 0 -> next cycle fb_valid_o=01, fb_pc_o[0]=0x100, fb_mispredict_o[0]=0, fb_conf_o[0]=1, occupancy_o back to 0.
REQ-033 SHALL cover this scenario: pred_valid_i=2'b10 (pc 0x200, result 7), then commit_valid_i=2'b10 with actual 9 -> fb_valid_o=01, fb_pc_o[0]=0x200, fb_actual_o[0]=9, fb_mispredict_o[0]=1.
REQ-034 SHALL cover this scenario: depth 16, push 2 per cycle for 9 cycles with no commits -> occupancy_o=16 after the 8th cycle, 9th-cycle pushes dropped, overflow_o=1; then same-cycle 2 commits + 2 pushes when full -> both pushes accepted, occupancy_o stays 16.
REQ-035 SHALL cover this scenario: 1 entry stored, commit_valid_i=2'b11 -> lane 0 feedback only, underflow_o=1, occupancy_o=0.
REQ-036 SHALL cover this scenario: 5 entries, flush_i=1 together with 2 pushes and 1 commit -> occupancy_o=0, fb_valid_o=00 next cycle, flags unchanged.
REQ-037 SHALL cover this scenario: 40 push/commit pairs through a depth-16 FIFO (pointer wrap) -> every feedback PC and mispredict matches the reference model in order; asserting rst_ni=0 mid-stream -> all outputs 0 immediately.
